// File: rtl/decode_pkg.sv
// Shared constants and helpers for the decode stage and its register file.
package decode_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned OP_W     = 7;

  localparam logic [OP_W-1:0] OP_LDB = 7'h10;
  localparam logic [OP_W-1:0] OP_LDW = 7'h11;

  // Instruction field positions
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 25;
  localparam int unsigned RD_MSB     = 24;
  localparam int unsigned RD_LSB     = 20;
  localparam int unsigned RS1_MSB    = 19;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_MSB    = 14;
  localparam int unsigned RS2_LSB    = 10;
  localparam int unsigned IMM_MSB    = 14;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic              valid;
  } dec_out_t;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LDB) || (op == OP_LDW);
  endfunction

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_MSB:0] imm);
    return {{(XLEN-IMM_MSB-1){imm[IMM_MSB]}}, imm};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports, one write port, r0 hardwired to zero.
// Define DECODE_WB_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] addr);
    if (addr == '0) return '0;
`ifdef DECODE_WB_BYPASS_EN
    if (we && (waddr == addr)) return wdata;
`endif
    return regs_q[addr];
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, register read, load-use hazard bubble, stall/flush control.
// Define DECODE_WB_BYPASS_EN to forward same-cycle write-back data into the register reads.
module decode_stage
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   instruction,
  input  logic [XLEN-1:0]   next_PC,
  input  logic              fetch_valid,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              wb_enable,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [OP_W-1:0]   opcode_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   imm_out,
  output logic [XLEN-1:0]   PC_out,
  output logic              valid_out,
  output logic              stall_out
);

  dec_out_t          out_d, out_q;
  logic [REG_AW-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic              hazard;

  assign rs1_addr = instruction[RS1_MSB:RS1_LSB];
  assign rs2_addr = instruction[RS2_MSB:RS2_LSB];

  regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_enable),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // Compares against the registered (possibly held) load, so it persists through stall_in.
  always_comb begin
    hazard = out_q.valid && is_load(out_q.opcode) && (out_q.rd != '0) && fetch_valid &&
             ((out_q.rd == rs1_addr) || (out_q.rd == rs2_addr));
    stall_out = stall_in | hazard;
  end

  always_comb begin
    out_d = out_q;
    if (flush) begin
      out_d.valid = 1'b0;
    end else if (stall_in) begin
      out_d = out_q;
    end else if (hazard || !fetch_valid) begin
      out_d.valid = 1'b0;
    end else begin
      out_d.opcode   = instruction[OPCODE_MSB:OPCODE_LSB];
      out_d.rd       = instruction[RD_MSB:RD_LSB];
      out_d.rs1_data = rf_rdata1;
      out_d.rs2_data = rf_rdata2;
      out_d.imm      = sext_imm(instruction[IMM_MSB:0]);
      out_d.pc       = next_PC;
      out_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign opcode_out = out_q.opcode;
  assign rd_out     = out_q.rd;
  assign rs1_data   = out_q.rs1_data;
  assign rs2_data   = out_q.rs2_data;
  assign imm_out    = out_q.imm;
  assign PC_out     = out_q.pc;
  assign valid_out  = out_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic vs a model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction, next_PC, wb_data;
  logic        fetch_valid, flush, stall_in, wb_enable;
  logic [4:0]  wb_addr;
  logic [6:0]  opcode_out;
  logic [4:0]  rd_out;
  logic [31:0] rs1_data, rs2_data, imm_out, PC_out;
  logic        valid_out, stall_out;

  int checks = 0;
  int failures = 0;

  decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .next_PC     (next_PC),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .stall_in    (stall_in),
    .wb_enable   (wb_enable),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .opcode_out  (opcode_out),
    .rd_out      (rd_out),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm_out     (imm_out),
    .PC_out      (PC_out),
    .valid_out   (valid_out),
    .stall_out   (stall_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [14:0] low);
    return {op, rd, rs1, low};
  endfunction

  // Reference model: architectural register array plus the last decoded instruction.
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [6:0]  m_op;
  logic [4:0]  m_rd;
  logic [31:0] m_r1, m_r2, m_imm, m_pc;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_enable && wb_addr == a) return wb_data;
`endif
    return m_rf[a];
  endfunction

  function automatic logic m_hazard();
    logic [4:0] s1, s2;
    s1 = instruction[19:15];
    s2 = instruction[14:10];
    return m_valid && (m_op == 7'h10 || m_op == 7'h11) && m_rd != 5'd0 && fetch_valid &&
           (m_rd == s1 || m_rd == s2);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_op <= '0; m_rd <= '0;
      m_r1 <= '0; m_r2 <= '0; m_imm <= '0; m_pc <= '0;
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
    end else begin
      if (flush || (!stall_in && (m_hazard() || !fetch_valid))) begin
        m_valid <= 1'b0;
      end else if (!stall_in) begin
        m_valid <= 1'b1;
        m_op    <= instruction[31:25];
        m_rd    <= instruction[24:20];
        m_r1    <= m_read(instruction[19:15]);
        m_r2    <= m_read(instruction[14:10]);
        m_imm   <= 32'($signed(instruction[14:0]));
        m_pc    <= next_PC;
      end
      if (wb_enable && wb_addr != 5'd0) m_rf[wb_addr] <= wb_data;
    end
  end

  always @(negedge clk) begin
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("opcode_out", 32'(opcode_out), 32'(m_op));
    chk("rd_out", 32'(rd_out), 32'(m_rd));
    chk("rs1_data", rs1_data, m_r1);
    chk("rs2_data", rs2_data, m_r2);
    chk("imm_out", imm_out, m_imm);
    chk("PC_out", PC_out, m_pc);
    chk("stall_out", 32'(stall_out), 32'(stall_in | m_hazard()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    instruction = '0; next_PC = '0; fetch_valid = 1'b0; flush = 1'b0; stall_in = 1'b1;
    wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
    #1 reset = 1'b1;
    tick();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pc", PC_out, 32'd0);
    chk("rst_rs1", rs1_data, 32'd0);
    chk("rst_stall_eq_stall_in", 32'(stall_out), 32'd1);
    reset = 1'b0; stall_in = 1'b0;

    // Write-back r3 with a same-cycle read of r3
    wb_enable = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    instruction = mk(7'h01, 5'd1, 5'd3, 15'h4000); next_PC = 32'h104; fetch_valid = 1'b1;
    tick();
`ifdef DECODE_WB_BYPASS_EN
    chk("wb_same_cycle_bypass", rs1_data, 32'hDEADBEEF);
`else
    chk("wb_same_cycle_old", rs1_data, 32'h0);
`endif
    chk("imm_sext", imm_out, 32'hFFFFC000);
    chk("pc_decode", PC_out, 32'h104);
    wb_enable = 1'b0;
    tick();
    chk("wb_read_r3", rs1_data, 32'hDEADBEEF);

    // r0 writes ignored; load to r0 never stalls
    wb_enable = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    instruction = mk(7'h01, 5'd2, 5'd0, 15'h0);
    tick();
    wb_enable = 1'b0;
    tick();
    chk("r0_read", rs2_data, 32'h0);
    instruction = mk(7'h11, 5'd0, 5'd1, 15'h0);
    tick();
    instruction = mk(7'h01, 5'd3, 5'd0, 15'h0);
    #1 chk("r0_no_stall", 32'(stall_out), 32'd0);
    tick();
    chk("r0_use_valid", 32'(valid_out), 32'd1);

    // Load-use hazard: LDW r7 then ADD using r7
    instruction = mk(7'h11, 5'd7, 5'd1, 15'h0); next_PC = 32'h200;
    tick();
    chk("ldw_opcode", 32'(opcode_out), 32'h11);
    instruction = mk(7'h01, 5'd8, 5'd7, 15'(2 << 10)); next_PC = 32'h204;
    #1 chk("hazard_stall", 32'(stall_out), 32'd1);
    tick();
    chk("bubble_valid", 32'(valid_out), 32'd0);
    chk("bubble_opcode_held", 32'(opcode_out), 32'h11);
    chk("post_bubble_stall", 32'(stall_out), 32'd0);
    tick();
    chk("add_valid", 32'(valid_out), 32'd1);
    chk("add_opcode", 32'(opcode_out), 32'h01);
    chk("add_pc", PC_out, 32'h204);

    // Stall hold for three cycles
    stall_in = 1'b1; instruction = mk(7'h02, 5'd9, 5'd1, 15'h0); next_PC = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc_hold", PC_out, 32'h204);
      chk("stall_valid_hold", 32'(valid_out), 32'd1);
      chk("stall_out_hold", 32'(stall_out), 32'd1);
    end
    flush = 1'b1;
    tick();
    chk("flush_over_stall", 32'(valid_out), 32'd0);
    flush = 1'b0; stall_in = 1'b0;

    // Reset mid-stream discards a pending write-back
    wb_enable = 1'b1; wb_addr = 5'd5; wb_data = 32'h12345678;
    instruction = mk(7'h01, 5'd4, 5'd5, 15'h0); next_PC = 32'h400;
    reset = 1'b1;
    #1 chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_pc", PC_out, 32'd0);
    tick();
    reset = 1'b0; wb_enable = 1'b0;
    instruction = mk(7'h01, 5'd1, 5'd5, 15'(5 << 10));
    tick();
    chk("r5_after_rst_rs1", rs1_data, 32'd0);
    chk("r5_after_rst_rs2", rs2_data, 32'd0);

    // Randomized traffic, small register range to provoke hazards and bypass hits
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 3))
        0: op = 7'h10;
        1: op = 7'h11;
        2: op = 7'h01;
        default: op = 7'($urandom);
      endcase
      instruction = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 10'($urandom)};
      next_PC     = $urandom;
      fetch_valid = ($urandom_range(0, 9) < 8);
      flush       = ($urandom_range(0, 9) == 0);
      stall_in    = ($urandom_range(0, 99) < 15);
      wb_enable   = ($urandom_range(0, 1) == 1);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      reset       = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
